// File: rtl/wb_stage_multi_pkg.sv
// Shared types and lane-bus field layout for the multi-issue writeback stage.
// Lane bus layout, MSB to LSB: {gr_we, dest, result, pc}.
package wb_stage_multi_pkg;

    typedef enum logic [0:0] {
        TR_IDLE  = 1'b0,
        TR_DRAIN = 1'b1
    } tr_state_e;

    function automatic int lane_wd(input int xlen, input int reg_aw);
        return 1 + reg_aw + 2 * xlen;
    endfunction

    function automatic int pc_lsb(input int xlen);
        return 0 * xlen;
    endfunction

    function automatic int result_lsb(input int xlen);
        return xlen;
    endfunction

    function automatic int dest_lsb(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int gr_we_bit(input int xlen, input int reg_aw);
        return 2 * xlen + reg_aw;
    endfunction

endpackage

// File: rtl/wb_stage_multi_trace_serializer.sv
// Serialises the held writeback group onto the debug trace port, one lane per beat,
// and tells the group register when the last beat has been taken.
//
// state    | meaning
// TR_IDLE  | no group held, nothing to offer
// TR_DRAIN | group held, offering the lowest pending lane as a beat
module wb_trace_serializer
    import wb_stage_multi_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_LANES-1:0]        es_valid,
    input  logic                        allowin,
    input  logic [NUM_LANES-1:0]        lane_wmask,
    input  logic [NUM_LANES*XLEN-1:0]   lane_pc,
    input  logic [NUM_LANES*REG_AW-1:0] lane_dest,
    input  logic [NUM_LANES*XLEN-1:0]   lane_result,
    input  logic                        trace_ready,
    output logic                        ws_ready_go,
    output logic                        trace_valid,
    output logic [XLEN-1:0]             trace_pc,
    output logic                        trace_we,
    output logic [REG_AW-1:0]           trace_wnum,
    output logic [XLEN-1:0]             trace_wdata
);

    localparam logic [NUM_LANES-1:0] ONE = 1;

    tr_state_e            state_q, state_d;
    logic [NUM_LANES-1:0] pending_q, pending_d;
    logic [NUM_LANES-1:0] pick;
    logic                 last_beat;
    logic                 handshake;
    logic                 accept_new;

    // Isolates the lowest set bit: the oldest lane still waiting for its beat.
    assign pick        = pending_q & (~pending_q + ONE);
    assign trace_valid = (state_q == TR_DRAIN);
    assign handshake   = trace_valid & trace_ready;
    assign last_beat   = trace_valid & ($countones(pending_q) == 1);
    assign ws_ready_go = last_beat & trace_ready;
    assign accept_new  = allowin & (|es_valid);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            TR_IDLE: begin
                if (accept_new) begin
                    pending_d = es_valid;
                    state_d   = TR_DRAIN;
                end
            end
            TR_DRAIN: begin
                if (handshake) begin
                    pending_d = pending_q & ~pick;
                    if (ws_ready_go) begin
                        if (accept_new) begin
                            pending_d = es_valid;
                        end else begin
                            state_d = TR_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= TR_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        trace_pc    = '0;
        trace_we    = 1'b0;
        trace_wnum  = '0;
        trace_wdata = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (pick[i]) begin
                trace_pc    = trace_pc    | lane_pc[i*XLEN +: XLEN];
                trace_we    = trace_we    | lane_wmask[i];
                trace_wnum  = trace_wnum  | lane_dest[i*REG_AW +: REG_AW];
                trace_wdata = trace_wdata | lane_result[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-issue writeback stage: holds one EX group, writes the regfile in program
// order (younger lane wins same-register collisions), forwards, counts retirements.
module wb_stage_multi
    import wb_stage_multi_pkg::*;
#(
    parameter int  NUM_LANES = 2,
    parameter int  XLEN      = 32,
    parameter int  REG_AW    = 5,
    parameter int  TRACE_EN  = 1,
    localparam int LANE_WD   = lane_wd(XLEN, REG_AW)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_LANES-1:0]         es_to_ws_valid,
    input  logic [NUM_LANES*LANE_WD-1:0] es_to_ws_bus,
    output logic                         ws_allowin,
    output logic [NUM_LANES-1:0]         rf_we,
    output logic [NUM_LANES*REG_AW-1:0]  rf_waddr,
    output logic [NUM_LANES*XLEN-1:0]    rf_wdata,
    output logic [NUM_LANES-1:0]         ws_fwd_valid,
    output logic [NUM_LANES*REG_AW-1:0]  ws_fwd_dest,
    output logic [NUM_LANES*XLEN-1:0]    ws_fwd_data,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [XLEN-1:0]              trace_pc,
    output logic                         trace_we,
    output logic [REG_AW-1:0]            trace_wnum,
    output logic [XLEN-1:0]              trace_wdata,
    output logic [63:0]                  instret
);

    localparam int PC_LSB  = pc_lsb(XLEN);
    localparam int RES_LSB = result_lsb(XLEN);
    localparam int DST_LSB = dest_lsb(XLEN);
    localparam int WE_BIT  = gr_we_bit(XLEN, REG_AW);

    logic [NUM_LANES-1:0] ws_valid_q, ws_valid_d;
    logic [LANE_WD-1:0]   bus_q [NUM_LANES];
    logic [LANE_WD-1:0]   bus_d [NUM_LANES];
    logic [63:0]          instret_q, instret_d;

    logic                 ws_ready_go;
    logic                 retire;
    logic [NUM_LANES-1:0] lane_gr_we;
    logic [NUM_LANES-1:0] lane_fwd;
    logic [NUM_LANES-1:0] wr_mask;
    logic [REG_AW-1:0]    lane_dest [NUM_LANES];
    logic [XLEN-1:0]      lane_res  [NUM_LANES];
    logic [NUM_LANES*XLEN-1:0] pc_flat;

    assign ws_allowin = (ws_valid_q == '0) | ws_ready_go;
    assign retire     = (|ws_valid_q) & ws_ready_go;
    assign instret    = instret_q;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_gr_we[i]             = bus_q[i][WE_BIT];
            lane_dest[i]              = bus_q[i][DST_LSB +: REG_AW];
            lane_res[i]               = bus_q[i][RES_LSB +: XLEN];
            pc_flat[i*XLEN +: XLEN]   = bus_q[i][PC_LSB +: XLEN];
        end
    end

    // A lane's write is suppressed when any younger valid lane writes the same register.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_fwd[i] = ws_valid_q[i] & lane_gr_we[i] & (lane_dest[i] != '0);
            wr_mask[i]  = lane_fwd[i];
            for (int j = 0; j < NUM_LANES; j++) begin
                if ((j > i) && ws_valid_q[j] && lane_gr_we[j] && (lane_dest[j] == lane_dest[i])) begin
                    wr_mask[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        ws_valid_d = ws_valid_q;
        bus_d      = bus_q;
        if (ws_allowin) begin
            ws_valid_d = es_to_ws_valid;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (es_to_ws_valid[i]) begin
                    bus_d[i] = es_to_ws_bus[i*LANE_WD +: LANE_WD];
                end
            end
        end
        instret_d = instret_q + (retire ? 64'($countones(ws_valid_q)) : 64'd0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid_q <= '0;
            instret_q  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                bus_q[i] <= '0;
            end
        end else begin
            ws_valid_q <= ws_valid_d;
            instret_q  <= instret_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                bus_q[i] <= bus_d[i];
            end
        end
    end

    always_comb begin
        rf_we        = retire ? wr_mask : '0;
        ws_fwd_valid = lane_fwd;
        for (int i = 0; i < NUM_LANES; i++) begin
            rf_waddr[i*REG_AW +: REG_AW]    = lane_dest[i];
            rf_wdata[i*XLEN +: XLEN]        = lane_res[i];
            ws_fwd_dest[i*REG_AW +: REG_AW] = lane_dest[i];
            ws_fwd_data[i*XLEN +: XLEN]     = lane_res[i];
        end
    end

    if (TRACE_EN != 0) begin : g_trace
        wb_trace_serializer #(
            .NUM_LANES (NUM_LANES),
            .XLEN      (XLEN),
            .REG_AW    (REG_AW)
        ) u_trace (
            .clk         (clk),
            .resetn      (resetn),
            .es_valid    (es_to_ws_valid),
            .allowin     (ws_allowin),
            .lane_wmask  (wr_mask),
            .lane_pc     (pc_flat),
            .lane_dest   (rf_waddr),
            .lane_result (rf_wdata),
            .trace_ready (trace_ready),
            .ws_ready_go (ws_ready_go),
            .trace_valid (trace_valid),
            .trace_pc    (trace_pc),
            .trace_we    (trace_we),
            .trace_wnum  (trace_wnum),
            .trace_wdata (trace_wdata)
        );
    end else begin : g_no_trace
        assign ws_ready_go = 1'b1;
        assign trace_valid = 1'b0;
        assign trace_pc    = '0;
        assign trace_we    = 1'b0;
        assign trace_wnum  = '0;
        assign trace_wdata = '0;
    end

endmodule

// File: tb/tb_wb_stage_multi.sv
// Bench for wb_stage_multi: one instance without trace, one with the serialised trace port.
module tb_wb_stage_multi;

    localparam int N  = 2;
    localparam int XL = 32;
    localparam int AW = 5;
    localparam int LW = 1 + AW + 2*XL;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] v0, v1, allow_unused;
    logic [N*LW-1:0] bus0, bus1;
    logic allow0, allow1, tv0, tv1, tr0, tr1, twe0, twe1;
    logic [N-1:0] rfwe0, rfwe1, fv0, fv1;
    logic [N*AW-1:0] waddr0, waddr1, fd0, fd1;
    logic [N*XL-1:0] wdata0, wdata1, fdat0, fdat1;
    logic [XL-1:0] tpc0, tpc1, twd0, twd1;
    logic [AW-1:0] twn0, twn1;
    logic [63:0] instret0, instret1;

    wb_stage_multi #(.NUM_LANES(N), .XLEN(XL), .REG_AW(AW), .TRACE_EN(0)) dut0 (
        .clk(clk), .resetn(resetn), .es_to_ws_valid(v0), .es_to_ws_bus(bus0),
        .ws_allowin(allow0), .rf_we(rfwe0), .rf_waddr(waddr0), .rf_wdata(wdata0),
        .ws_fwd_valid(fv0), .ws_fwd_dest(fd0), .ws_fwd_data(fdat0),
        .trace_valid(tv0), .trace_ready(tr0), .trace_pc(tpc0), .trace_we(twe0),
        .trace_wnum(twn0), .trace_wdata(twd0), .instret(instret0));

    wb_stage_multi #(.NUM_LANES(N), .XLEN(XL), .REG_AW(AW), .TRACE_EN(1)) dut1 (
        .clk(clk), .resetn(resetn), .es_to_ws_valid(v1), .es_to_ws_bus(bus1),
        .ws_allowin(allow1), .rf_we(rfwe1), .rf_waddr(waddr1), .rf_wdata(wdata1),
        .ws_fwd_valid(fv1), .ws_fwd_dest(fd1), .ws_fwd_data(fdat1),
        .trace_valid(tv1), .trace_ready(tr1), .trace_pc(tpc1), .trace_we(twe1),
        .trace_wnum(twn1), .trace_wdata(twd1), .instret(instret1));

    int vectors = 0;
    int miscompares = 0;
    logic [XL-1:0] pc_ctr = 32'h1000;

    typedef struct {
        logic [XL-1:0] pc;
        logic          we;
        logic [AW-1:0] wn;
        logic [XL-1:0] wd;
    } beat_t;

    beat_t       cur_q[$];
    logic [N-1:0] cur_mask;
    longint      cur_cnt;
    logic [63:0] inst_m1;

    typedef struct {
        logic [N-1:0]  v;
        logic [N-1:0]  we;
        logic [AW-1:0] d0, d1;
        logic [XL-1:0] r0, r1;
        logic [N-1:0]  exp_rfwe;
        logic [N-1:0]  exp_fwd;
        logic [63:0]   exp_instret;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] mk(input logic we, input logic [AW-1:0] d,
                                         input logic [XL-1:0] r, input logic [XL-1:0] pc);
        return {we, d, r, pc};
    endfunction

    // Program-order writes: the last valid writer of each register is the one that lands.
    function automatic logic [N-1:0] exp_mask(input logic [N-1:0] v, input logic [N*LW-1:0] b);
        int last_wr [32];
        logic [N-1:0] m;
        for (int r = 0; r < 32; r++) last_wr[r] = -1;
        for (int i = 0; i < N; i++)
            if (v[i] && b[i*LW + LW - 1]) last_wr[b[i*LW + 2*XL +: AW]] = i;
        for (int i = 0; i < N; i++)
            m[i] = v[i] && b[i*LW + LW - 1] && (b[i*LW + 2*XL +: AW] != 0)
                   && (last_wr[b[i*LW + 2*XL +: AW]] == i);
        return m;
    endfunction

    function automatic logic [N-1:0] exp_fwd(input logic [N-1:0] v, input logic [N*LW-1:0] b);
        logic [N-1:0] f;
        for (int i = 0; i < N; i++)
            f[i] = v[i] && b[i*LW + LW - 1] && (b[i*LW + 2*XL +: AW] != 0);
        return f;
    endfunction

    task automatic rnd_group(output logic [N-1:0] v, output logic [N*LW-1:0] b);
        v = N'($urandom_range(0, (1 << N) - 1));
        for (int i = 0; i < N; i++) begin
            b[i*LW +: LW] = mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom, pc_ctr);
            pc_ctr = pc_ctr + 4;
        end
    endtask

    // One cycle of random traffic on the traced instance against the beat-queue model.
    task automatic cyc1(input bit allow_new);
        logic [N-1:0] v;
        logic [N*LW-1:0] b;
        bit rdy, ex_allow;
        logic [N-1:0] ex_rfwe;
        beat_t bt;
        rnd_group(v, b);
        if (!allow_new) v = '0;
        rdy = ($urandom_range(0, 3) != 0) || !allow_new;
        v1 = v; bus1 = b; tr1 = rdy;
        #1;
        chk("rnd_trace_valid", tv1, cur_q.size() != 0);
        if (cur_q.size() != 0) begin
            chk("rnd_trace_pc", tpc1, cur_q[0].pc);
            chk("rnd_trace_we", twe1, cur_q[0].we);
            chk("rnd_trace_wnum", twn1, cur_q[0].wn);
            chk("rnd_trace_wdata", twd1, cur_q[0].wd);
        end
        ex_allow = (cur_q.size() == 0) || (cur_q.size() == 1 && rdy);
        ex_rfwe  = (cur_q.size() == 1 && rdy) ? cur_mask : '0;
        chk("rnd_allowin", allow1, ex_allow);
        chk("rnd_rf_we", rfwe1, ex_rfwe);
        chk("rnd_instret", instret1, inst_m1);
        if (cur_q.size() != 0 && rdy) begin
            if (cur_q.size() == 1) inst_m1 = inst_m1 + 64'(cur_cnt);
            void'(cur_q.pop_front());
        end
        if (ex_allow && v != '0) begin
            cur_mask = exp_mask(v, b);
            cur_cnt  = $countones(v);
            for (int i = 0; i < N; i++) begin
                if (v[i]) begin
                    bt.pc = b[i*LW +: XL];
                    bt.we = cur_mask[i];
                    bt.wn = b[i*LW + 2*XL +: AW];
                    bt.wd = b[i*LW + XL +: XL];
                    cur_q.push_back(bt);
                end
            end
        end
        step();
    endtask

    initial begin
        logic [63:0] inst_m0;
        logic [N-1:0] rv;
        logic [N*LW-1:0] rb;

        tbl[0] = '{2'b11, 2'b11, 5'd5, 5'd6,  32'h11, 32'h22, 2'b11, 2'b11, 64'd0};
        tbl[1] = '{2'b11, 2'b11, 5'd7, 5'd7,  32'hA,  32'hB,  2'b10, 2'b11, 64'd2};
        tbl[2] = '{2'b01, 2'b11, 5'd0, 5'd12, 32'h33, 32'h44, 2'b00, 2'b00, 64'd4};
        tbl[3] = '{2'b00, 2'b11, 5'd1, 5'd2,  32'h55, 32'h66, 2'b00, 2'b00, 64'd5};
        tbl[4] = '{2'b10, 2'b11, 5'd3, 5'd9,  32'h77, 32'h33, 2'b10, 2'b10, 64'd5};
        tbl[5] = '{2'b11, 2'b10, 5'd4, 5'd4,  32'h88, 32'h44, 2'b10, 2'b10, 64'd6};
        tbl[6] = '{2'b11, 2'b01, 5'd8, 5'd8,  32'h55, 32'h66, 2'b01, 2'b01, 64'd8};

        v0 = '0; bus0 = '0; tr0 = 1'b0;
        v1 = '0; bus1 = '0; tr1 = 1'b0;
        allow_unused = '0;
        #3;
        chk("rst_trace_valid", tv1, 1'b0);
        chk("rst_rf_we", rfwe1, '0);
        chk("rst_instret", instret1, 64'd0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        step();
        chk("rst_allowin0", allow0, 1'b1);
        chk("rst_allowin1", allow1, 1'b1);
        chk("rst_fwd_valid0", fv0, '0);
        chk("rst_rf_wdata0", wdata0, '0);
        chk("rst_instret0", instret0, 64'd0);

        // Reset while the traced instance is mid-drain.
        v1 = 2'b11;
        bus1 = {mk(1'b1, 5'd6, 32'h22, 32'h104), mk(1'b1, 5'd5, 32'h11, 32'h100)};
        step();
        v1 = '0;
        chk("mid_drain_tv", tv1, 1'b1);
        chk("mid_drain_allowin", allow1, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("reset_drops_tv", tv1, 1'b0);
        chk("reset_no_rfwe", rfwe1, '0);
        chk("reset_instret", instret1, 64'd0);
        #3 resetn = 1'b1;
        tr1 = 1'b1;
        step();
        chk("post_reset_tv", tv1, 1'b0);
        chk("post_reset_allowin", allow1, 1'b1);
        step();
        chk("post_reset_no_beat", tv1, 1'b0);
        chk("post_reset_instret", instret1, 64'd0);

        // Untraced instance: table of groups, one per cycle.
        for (int k = 0; k < 7; k++) begin
            v0 = tbl[k].v;
            bus0 = {mk(tbl[k].we[1], tbl[k].d1, tbl[k].r1, 32'h200 + 32'(k)),
                    mk(tbl[k].we[0], tbl[k].d0, tbl[k].r0, 32'h100 + 32'(k))};
            step();
            chk($sformatf("tbl%0d_rf_we", k), rfwe0, tbl[k].exp_rfwe);
            chk($sformatf("tbl%0d_fwd_valid", k), fv0, tbl[k].exp_fwd);
            chk($sformatf("tbl%0d_instret", k), instret0, tbl[k].exp_instret);
            chk($sformatf("tbl%0d_allowin", k), allow0, 1'b1);
            if (tbl[k].exp_rfwe[0]) begin
                chk($sformatf("tbl%0d_waddr0", k), waddr0[0 +: AW], tbl[k].d0);
                chk($sformatf("tbl%0d_wdata0", k), wdata0[0 +: XL], tbl[k].r0);
            end
            if (tbl[k].exp_rfwe[1]) begin
                chk($sformatf("tbl%0d_waddr1", k), waddr0[AW +: AW], tbl[k].d1);
                chk($sformatf("tbl%0d_wdata1", k), wdata0[XL +: XL], tbl[k].r1);
            end
        end
        v0 = '0;
        step();
        chk("tbl_final_instret", instret0, 64'd10);
        chk("tbl_idle_rf_we", rfwe0, '0);

        // Untraced instance: random groups against the program-order model.
        inst_m0 = 64'd10;
        for (int c = 0; c < 200; c++) begin
            rnd_group(rv, rb);
            v0 = rv; bus0 = rb;
            step();
            chk("rnd0_rf_we", rfwe0, exp_mask(rv, rb));
            chk("rnd0_fwd_valid", fv0, exp_fwd(rv, rb));
            chk("rnd0_instret", instret0, inst_m0);
            inst_m0 = inst_m0 + 64'($countones(rv));
        end
        v0 = '0;
        step();
        chk("rnd0_final_instret", instret0, inst_m0);

        // Traced: consumer stalls three cycles on the first beat.
        tr1 = 1'b0;
        v1 = 2'b11;
        bus1 = {mk(1'b1, 5'd6, 32'h22, 32'h104), mk(1'b1, 5'd5, 32'h11, 32'h100)};
        step();
        v1 = '0;
        chk("stall_tv", tv1, 1'b1);
        chk("stall_pc", tpc1, 32'h100);
        chk("stall_allowin", allow1, 1'b0);
        chk("stall_rf_we", rfwe1, '0);
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall_hold_tv", tv1, 1'b1);
            chk("stall_hold_pc", tpc1, 32'h100);
            chk("stall_hold_wnum", twn1, 5'd5);
            chk("stall_hold_allowin", allow1, 1'b0);
        end
        tr1 = 1'b1;
        #1;
        chk("beat0_no_rf_we", rfwe1, '0);
        chk("beat0_allowin", allow1, 1'b0);
        step();
        chk("beat1_pc", tpc1, 32'h104);
        chk("beat1_wnum", twn1, 5'd6);
        chk("beat1_wdata", twd1, 32'h22);
        chk("beat1_we", twe1, 1'b1);
        chk("beat1_rf_we", rfwe1, 2'b11);
        chk("beat1_allowin", allow1, 1'b1);
        step();
        chk("after_drain_tv", tv1, 1'b0);
        chk("after_drain_instret", instret1, 64'd2);

        // Traced: single-lane group, then a colliding group accepted back-to-back.
        v1 = 2'b10;
        bus1 = {mk(1'b1, 5'd9, 32'h99, 32'h200), mk(1'b1, 5'd3, 32'hDEAD, 32'h1FC)};
        step();
        v1 = 2'b11;
        bus1 = {mk(1'b1, 5'd10, 32'hA1, 32'h304), mk(1'b1, 5'd10, 32'hA0, 32'h300)};
        #1;
        chk("single_pc", tpc1, 32'h200);
        chk("single_wnum", twn1, 5'd9);
        chk("single_rf_we", rfwe1, 2'b10);
        chk("single_allowin", allow1, 1'b1);
        step();
        v1 = '0;
        chk("b2b_tv", tv1, 1'b1);
        chk("b2b_pc", tpc1, 32'h300);
        chk("b2b_we_collided", twe1, 1'b0);
        chk("b2b_instret", instret1, 64'd3);
        step();
        chk("b2b_pc1", tpc1, 32'h304);
        chk("b2b_we1", twe1, 1'b1);
        chk("b2b_wdata1", twd1, 32'hA1);
        chk("b2b_rf_we", rfwe1, 2'b10);
        step();
        chk("b2b_done_tv", tv1, 1'b0);
        chk("b2b_done_instret", instret1, 64'd5);

        // Traced: random groups and random backpressure.
        inst_m1 = 64'd5;
        cur_mask = '0;
        cur_cnt = 0;
        for (int c = 0; c < 300; c++) cyc1(1'b1);
        for (int c = 0; c < 4; c++) cyc1(1'b0);
        chk("rnd1_final_instret", instret1, inst_m1);
        chk("rnd1_final_tv", tv1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
